alu: RTL and testbench



---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_if.sv | 22 ++
 rtl/alu.sv | 72 +++++++
 tb/tb_alu.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU encoding: operation classes and full 6-bit control codes.
// Imported by the ALU and by the execute-stage encoder so both sides
// agree on the {class[2:0], funct3} layout.
package alu_pkg;

  // Operation classes (ALU_Control[5:3])
  localparam logic [2:0] ALU_CLS_ARITH  = 3'b000;
  localparam logic [2:0] ALU_CLS_ALT    = 3'b001;
  localparam logic [2:0] ALU_CLS_BRANCH = 3'b010;
  localparam logic [2:0] ALU_CLS_PASS   = 3'b011;

  // Arithmetic / logic / shift / set-less-than
  localparam logic [5:0] ALU_ADD  = {ALU_CLS_ARITH, 3'b000};
  localparam logic [5:0] ALU_SLL  = {ALU_CLS_ARITH, 3'b001};
  localparam logic [5:0] ALU_SLT  = {ALU_CLS_ARITH, 3'b010};
  localparam logic [5:0] ALU_SLTU = {ALU_CLS_ARITH, 3'b011};
  localparam logic [5:0] ALU_XOR  = {ALU_CLS_ARITH, 3'b100};
  localparam logic [5:0] ALU_SRL  = {ALU_CLS_ARITH, 3'b101};
  localparam logic [5:0] ALU_OR   = {ALU_CLS_ARITH, 3'b110};
  localparam logic [5:0] ALU_AND  = {ALU_CLS_ARITH, 3'b111};

  // funct7[5] variants
  localparam logic [5:0] ALU_SUB  = {ALU_CLS_ALT, 3'b000};
  localparam logic [5:0] ALU_SRA  = {ALU_CLS_ALT, 3'b101};

  // Branch compares (result is 0 or 1)
  localparam logic [5:0] ALU_BEQ  = {ALU_CLS_BRANCH, 3'b000};
  localparam logic [5:0] ALU_BNE  = {ALU_CLS_BRANCH, 3'b001};
  localparam logic [5:0] ALU_BLT  = {ALU_CLS_BRANCH, 3'b100};
  localparam logic [5:0] ALU_BGE  = {ALU_CLS_BRANCH, 3'b101};
  localparam logic [5:0] ALU_BLTU = {ALU_CLS_BRANCH, 3'b110};
  localparam logic [5:0] ALU_BGEU = {ALU_CLS_BRANCH, 3'b111};

  // Pass-through of operand A (JAL/JALR link value)
  localparam logic [5:0] ALU_PASS = {ALU_CLS_PASS, 3'b111};

endpackage

// File: rtl/alu_if.sv
// Operand/control in, result/flags out bundle between the execute stage
// (master) and the ALU (slave). Purely combinational, no handshake.
interface alu_if #(parameter int DATA_WIDTH = 32);

  logic [5:0]            ALU_Control;
  logic [DATA_WIDTH-1:0] operand_A;
  logic [DATA_WIDTH-1:0] operand_B;
  logic [DATA_WIDTH-1:0] ALU_result;
  logic                  zero;
  logic                  branch;

  modport master (
    output ALU_Control, operand_A, operand_B,
    input  ALU_result, zero, branch
  );

  modport slave (
    input  ALU_Control, operand_A, operand_B,
    output ALU_result, zero, branch
  );

endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU. The datapath has no registers; clock/reset only
// drive a free-running cycle counter kept for simulation reporting.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic clock,
  input  logic reset,
  alu_if.slave bus
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [DATA_WIDTH-1:0] result;
  logic [SHAMT_W-1:0]    shamt;
  logic                  eq;
  logic                  lt_s;
  logic                  lt_u;
  logic [31:0]           cycle_count;

  assign a     = bus.operand_A;
  assign b     = bus.operand_B;
  // Upper bits of B are deliberately ignored for shifts.
  assign shamt = b[SHAMT_W-1:0];

  // Shared comparators feed both the set-less-than and branch codes.
  assign eq   = (a == b);
  assign lt_s = ($signed(a) < $signed(b));
  assign lt_u = (a < b);

  // Operation decode: one result per control code, zero for unused codes.
  always_comb begin
    // NOTE: default assigned first so every path drives result and no latch is inferred.
    result = '0;
    case (bus.ALU_Control)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = DATA_WIDTH'(lt_s);
      ALU_SLTU: result = DATA_WIDTH'(lt_u);
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_BEQ:  result = DATA_WIDTH'(eq);
      ALU_BNE:  result = DATA_WIDTH'(!eq);
      ALU_BLT:  result = DATA_WIDTH'(lt_s);
      ALU_BGE:  result = DATA_WIDTH'(!lt_s);
      ALU_BLTU: result = DATA_WIDTH'(lt_u);
      ALU_BGEU: result = DATA_WIDTH'(!lt_u);
      ALU_PASS: result = a;
      default:  result = '0;
    endcase
  end

  assign bus.ALU_result = result;
  assign bus.zero       = (result == '0);
  // Only branch-class codes may raise branch; SLT true etc. must not.
  assign bus.branch     = (bus.ALU_Control[4:3] == 2'b10) && (result == DATA_WIDTH'(1));

  // Free-running cycle counter, cleared synchronously by reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (reset) cycle_count <= '0;
    else       cycle_count <= cycle_count + 32'd1;
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the combinational ALU.
module tb_alu;
  import alu_pkg::*;

  localparam int DW = 32;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        br;
  } vec_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  alu_if #(.DATA_WIDTH(DW)) bus ();

  alu #(.DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive on the falling edge, sample 2 time units later (clear of posedge).
  task automatic drive(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.ALU_Control = op;
    bus.operand_A   = a;
    bus.operand_B   = b;
    #2;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.ALU_result !== 32'hF000_F000) begin
        n_fail++;
        $display("FAIL reset_and cyc%0d: got %h want %h", i, bus.ALU_result, 32'hF000_F000);
      end
      n_checks++;
      if (bus.zero !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_zero cyc%0d: got %b want 0", i, bus.zero);
      end
      @(negedge clock);
      #2;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (dut.cycle_count !== 32'd0) begin
      n_fail++;
      $display("FAIL counter_after_reset: got %0d want 0", dut.cycle_count);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (dut.cycle_count !== 32'd1) begin
      n_fail++;
      $display("FAIL counter_increment: got %0d want 1", dut.cycle_count);
    end
  endtask

  task automatic test_arith;
    vec_t v[7];
    v = '{
      '{"add_ovf",  ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0},
      '{"sub_eq",   ALU_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0},
      '{"sub_wrap", ALU_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{"add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0},
      '{"xor",      ALU_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0},
      '{"or",       ALU_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0},
      '{"and",      ALU_AND, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h0000_0000, 1'b1, 1'b0}
    };
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b);
      n_checks++;
      if (bus.ALU_result !== v[i].res) begin
        n_fail++;
        $display("FAIL %s result: got %h want %h", v[i].name, bus.ALU_result, v[i].res);
      end
      n_checks++;
      if (bus.zero !== v[i].z || bus.branch !== v[i].br) begin
        n_fail++;
        $display("FAIL %s flags: got z=%b br=%b want z=%b br=%b", v[i].name,
                 bus.zero, bus.branch, v[i].z, v[i].br);
      end
    end
  endtask

  task automatic test_shift;
    vec_t v[6];
    v = '{
      '{"sll_1",     ALU_SLL, 32'h8000_0000, 32'h0000_0021, 32'h0000_0000, 1'b1, 1'b0},
      '{"srl_1",     ALU_SRL, 32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0, 1'b0},
      '{"sra_1",     ALU_SRA, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1'b0},
      '{"sra_31",    ALU_SRA, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 1'b0},
      '{"sll_0",     ALU_SLL, 32'h1234_5678, 32'hFFFF_FFE0, 32'h1234_5678, 1'b0, 1'b0},
      '{"srl_4",     ALU_SRL, 32'hF000_0001, 32'h0000_0004, 32'h0F00_0000, 1'b0, 1'b0}
    };
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b);
      n_checks++;
      if (bus.ALU_result !== v[i].res) begin
        n_fail++;
        $display("FAIL %s result: got %h want %h", v[i].name, bus.ALU_result, v[i].res);
      end
      n_checks++;
      if (bus.zero !== v[i].z || bus.branch !== v[i].br) begin
        n_fail++;
        $display("FAIL %s flags: got z=%b br=%b want z=%b br=%b", v[i].name,
                 bus.zero, bus.branch, v[i].z, v[i].br);
      end
    end
  endtask

  task automatic test_compare;
    vec_t v[3];
    v = '{
      '{"slt_true",  ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0},
      '{"sltu_false",ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0},
      '{"sltu_true", ALU_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0}
    };
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b);
      n_checks++;
      if (bus.ALU_result !== v[i].res) begin
        n_fail++;
        $display("FAIL %s result: got %h want %h", v[i].name, bus.ALU_result, v[i].res);
      end
      n_checks++;
      if (bus.zero !== v[i].z || bus.branch !== v[i].br) begin
        n_fail++;
        $display("FAIL %s flags: got z=%b br=%b want z=%b br=%b", v[i].name,
                 bus.zero, bus.branch, v[i].z, v[i].br);
      end
    end
  endtask

  task automatic test_branch;
    vec_t v[8];
    v = '{
      '{"blt",      ALU_BLT,  32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b1},
      '{"bge",      ALU_BGE,  32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0},
      '{"bltu",     ALU_BLTU, 32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0},
      '{"bgeu",     ALU_BGEU, 32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b1},
      '{"beq",      ALU_BEQ,  32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0},
      '{"bne",      ALU_BNE,  32'hFFFF_FFFE, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b1},
      '{"beq_equal",ALU_BEQ,  32'h0000_0042, 32'h0000_0042, 32'h0000_0001, 1'b0, 1'b1},
      '{"bge_equal",ALU_BGE,  32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1}
    };
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b);
      n_checks++;
      if (bus.ALU_result !== v[i].res) begin
        n_fail++;
        $display("FAIL %s result: got %h want %h", v[i].name, bus.ALU_result, v[i].res);
      end
      n_checks++;
      if (bus.zero !== v[i].z || bus.branch !== v[i].br) begin
        n_fail++;
        $display("FAIL %s flags: got z=%b br=%b want z=%b br=%b", v[i].name,
                 bus.zero, bus.branch, v[i].z, v[i].br);
      end
    end
  endtask

  task automatic test_pass_default;
    vec_t v[5];
    v = '{
      '{"pass",     ALU_PASS, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0104, 1'b0, 1'b0},
      '{"undef_012",6'o12,    32'h0000_0104, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 1'b0},
      '{"undef_022",6'o22,    32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0},
      '{"undef_030",6'o30,    32'h0000_0104, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0},
      '{"undef_060",6'o60,    32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0}
    };
    foreach (v[i]) begin
      drive(v[i].op, v[i].a, v[i].b);
      n_checks++;
      if (bus.ALU_result !== v[i].res) begin
        n_fail++;
        $display("FAIL %s result: got %h want %h", v[i].name, bus.ALU_result, v[i].res);
      end
      n_checks++;
      if (bus.zero !== v[i].z || bus.branch !== v[i].br) begin
        n_fail++;
        $display("FAIL %s flags: got z=%b br=%b want z=%b br=%b", v[i].name,
                 bus.zero, bus.branch, v[i].z, v[i].br);
      end
    end
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset           = 1'b0;
    bus.ALU_Control = '0;
    bus.operand_A   = '0;
    bus.operand_B   = '0;

    test_reset();
    test_arith();
    test_shift();
    test_compare();
    test_branch();
    test_pass_default();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
